// File: rtl/chip_bus_pkg.sv
// chip_bus_pkg: shared widths, stride and word/address/count types for the chip-bus endpoint
package chip_bus_pkg;
    localparam int DATA_W      = 64;
    localparam int ADDR_W      = 32;
    localparam int ADDR_STRIDE = 8;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [15:0]       count_t;
endpackage

// File: rtl/chip_bus_parity.sv
// chip_bus_parity: combinational even-parity bit (XOR reduction) of a data word
module chip_bus_parity #(
    parameter int W = 64
) (
    input  logic [W-1:0] par_data,
    output logic         par_bit
);
    assign par_bit = ^par_data;
endmodule

// File: rtl/chip_bus_modport.sv
// chip_bus_modport: clocked Read address issuer plus parity service; CHIP_BUS_CALL_COUNT_EN adds saturating call counters
module chip_bus_modport #(
    parameter int                DATA_W      = chip_bus_pkg::DATA_W,
    parameter int                ADDR_W      = chip_bus_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] ADDR_BASE   = '0,
    parameter int                ADDR_STRIDE = chip_bus_pkg::ADDR_STRIDE
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              rd_req,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_ack,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data_q,
    input  logic              par_req,
    input  logic [DATA_W-1:0] par_data,
    output logic              par_bit,
    output logic [15:0]       rd_calls,
    output logic [15:0]       par_calls
);
    import chip_bus_pkg::*;

    logic [ADDR_W-1:0] addr_ptr;

    chip_bus_parity #(.W(DATA_W)) u_parity (
        .par_data (par_data),
        .par_bit  (par_bit)
    );

    // accept every requested Read: pulse ack, publish the current pointer, then advance it (wrapping)
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rd_ack    <= 1'b0;
            rd_addr   <= '0;
            rd_data_q <= '0;
            addr_ptr  <= ADDR_BASE;
        end else begin
            rd_ack <= rd_req;
            if (rd_req) begin
                rd_addr   <= addr_ptr;
                rd_data_q <= rd_data;
                addr_ptr  <= addr_ptr + ADDR_W'(ADDR_STRIDE);
            end
        end
    end

`ifdef CHIP_BUS_CALL_COUNT_EN
    count_t rd_cnt, par_cnt;

    // saturating call counters, stuck at all-ones once full
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rd_cnt  <= '0;
            par_cnt <= '0;
        end else begin
            rd_cnt  <= rd_cnt + count_t'(rd_req && rd_cnt != '1);
            par_cnt <= par_cnt + count_t'(par_req && par_cnt != '1);
        end
    end

    assign rd_calls  = rd_cnt;
    assign par_calls = par_cnt;
`else
    logic unused_par_req;
    assign unused_par_req = par_req;
    assign rd_calls  = '0;
    assign par_calls = '0;
`endif
endmodule

// File: tb/tb_chip_bus_modport.sv
// tb_chip_bus_modport: table-driven checks of Read sequencing, parity, address wrap, async reset and counters
module tb_chip_bus_modport;
    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        rd_req = 1'b0;
    logic [63:0] rd_data = '0;
    logic        par_req = 1'b0;
    logic [63:0] par_data = '0;
    logic        rd_ack, w_ack, par_bit, w_par;
    logic [31:0] rd_addr, w_addr;
    logic [63:0] rd_data_q, w_data_q;
    logic [15:0] rd_calls, par_calls, w_rd_calls, w_par_calls;
    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int par_cnt = 0;

    typedef struct {
        logic        rd_req;
        logic [63:0] rd_data;
        logic        par_req;
        logic [63:0] par_data;
        logic        ack;
        logic [31:0] addr;
        logic [63:0] dq;
        logic        par;
        logic [31:0] waddr;
    } vec_t;

    vec_t vec [8];

    always #5 clock = ~clock;

    chip_bus_modport dut (
        .clock(clock), .resetN(resetN), .rd_req(rd_req), .rd_data(rd_data),
        .rd_ack(rd_ack), .rd_addr(rd_addr), .rd_data_q(rd_data_q),
        .par_req(par_req), .par_data(par_data), .par_bit(par_bit),
        .rd_calls(rd_calls), .par_calls(par_calls)
    );

    chip_bus_modport #(.ADDR_BASE(32'hFFFF_FFF8)) dut_wrap (
        .clock(clock), .resetN(resetN), .rd_req(rd_req), .rd_data(rd_data),
        .rd_ack(w_ack), .rd_addr(w_addr), .rd_data_q(w_data_q),
        .par_req(par_req), .par_data(par_data), .par_bit(w_par),
        .rd_calls(w_rd_calls), .par_calls(w_par_calls)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic check_counts(input string name);
`ifdef CHIP_BUS_CALL_COUNT_EN
        check({name, " rd_calls"}, 64'(rd_calls), 64'(rd_cnt));
        check({name, " par_calls"}, 64'(par_calls), 64'(par_cnt));
`else
        check({name, " rd_calls"}, 64'(rd_calls), 64'h0);
        check({name, " par_calls"}, 64'(par_calls), 64'h0);
`endif
    endtask

    initial begin
        vec[0] = '{1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 32'h0,  64'h0123_4567_89AB_CDEF, 1'b0, 32'hFFFF_FFF8};
        vec[1] = '{1'b0, 64'h0,                   1'b0, 64'h1,                   1'b0, 32'h0,  64'h0123_4567_89AB_CDEF, 1'b1, 32'hFFFF_FFF8};
        vec[2] = '{1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 32'd8,  64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 32'h0};
        vec[3] = '{1'b1, 64'h5555_5555_5555_5555, 1'b1, 64'h0,                   1'b1, 32'd16, 64'h5555_5555_5555_5555, 1'b0, 32'd8};
        vec[4] = '{1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 64'h0,                   1'b1, 32'd24, 64'hDEAD_BEEF_0000_0001, 1'b0, 32'd16};
        vec[5] = '{1'b0, 64'h0,                   1'b1, 64'h8000_0000_0000_0001, 1'b0, 32'd24, 64'hDEAD_BEEF_0000_0001, 1'b0, 32'd16};
        vec[6] = '{1'b0, 64'h0,                   1'b0, 64'h7,                   1'b0, 32'd24, 64'hDEAD_BEEF_0000_0001, 1'b1, 32'd16};
        vec[7] = '{1'b1, 64'hCAFE,                1'b0, 64'h8000_0000_0000_0000, 1'b1, 32'd32, 64'hCAFE,                1'b1, 32'd24};

        repeat (2) @(posedge clock);
        #1;
        check("reset rd_ack", 64'(rd_ack), 64'h0);
        check("reset rd_addr", 64'(rd_addr), 64'h0);
        check("reset rd_data_q", rd_data_q, 64'h0);
        check("reset wrap rd_addr", 64'(w_addr), 64'h0);
        check_counts("reset");
        @(negedge clock);
        resetN = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            rd_req = vec[i].rd_req;
            rd_data = vec[i].rd_data;
            par_req = vec[i].par_req;
            par_data = vec[i].par_data;
            #1;
            check($sformatf("vec%0d par_bit comb", i), 64'(par_bit), 64'(vec[i].par));
            @(posedge clock);
            #1;
            if (vec[i].rd_req) rd_cnt = rd_cnt + 1;
            if (vec[i].par_req) par_cnt = par_cnt + 1;
            check($sformatf("vec%0d rd_ack", i), 64'(rd_ack), 64'(vec[i].ack));
            check($sformatf("vec%0d rd_addr", i), 64'(rd_addr), 64'(vec[i].addr));
            check($sformatf("vec%0d rd_data_q", i), rd_data_q, vec[i].dq);
            check($sformatf("vec%0d par_bit", i), 64'(par_bit), 64'(vec[i].par));
            check($sformatf("vec%0d wrap rd_addr", i), 64'(w_addr), 64'(vec[i].waddr));
            check_counts($sformatf("vec%0d", i));
        end

        @(negedge clock);
        rd_req = 1'b1;
        rd_data = 64'h1111_2222_3333_4444;
        par_req = 1'b0;
        @(posedge clock);
        #1;
        check("pre-reset rd_ack", 64'(rd_ack), 64'h1);
        check("pre-reset rd_addr", 64'(rd_addr), 64'd40);
        #2;
        resetN = 1'b0;
        #1;
        check("async reset rd_ack", 64'(rd_ack), 64'h0);
        check("async reset rd_addr", 64'(rd_addr), 64'h0);
        check("async reset rd_data_q", rd_data_q, 64'h0);
        rd_cnt = 0;
        par_cnt = 0;
        check_counts("async reset");
        @(posedge clock);
        #1;
        check("req in reset rd_ack", 64'(rd_ack), 64'h0);
        @(negedge clock);
        resetN = 1'b1;
        rd_data = 64'h5A5A_0000_FFFF_0001;
        @(posedge clock);
        #1;
        rd_cnt = 1;
        check("post-reset rd_ack", 64'(rd_ack), 64'h1);
        check("post-reset rd_addr", 64'(rd_addr), 64'h0);
        check("post-reset rd_data_q", rd_data_q, 64'h5A5A_0000_FFFF_0001);
        check("post-reset wrap rd_addr", 64'(w_addr), 64'hFFFF_FFF8);
        check_counts("post-reset");
        @(negedge clock);
        rd_req = 1'b0;
        @(posedge clock);
        #1;
        check("post-reset ack drop", 64'(rd_ack), 64'h0);
        check("post-reset hold addr", 64'(rd_addr), 64'h0);

`ifdef CHIP_BUS_CALL_COUNT_EN
        @(negedge clock);
        par_req = 1'b1;
        repeat (65540) @(posedge clock);
        #1;
        check("par_calls saturated", 64'(par_calls), 64'hFFFF);
        check("rd_calls during saturation", 64'(rd_calls), 64'h1);
        par_req = 1'b0;
`else
        check_counts("end");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/chip_bus_modport.md
# chip_bus_modport

Shared chip-bus endpoint that a chip-side client uses for two services: a Read operation and a parity generator. Read accepts a 64-bit data word and returns the 32-bit bus address assigned to that word. Parity returns the even-parity bit of a 64-bit word. The block sits between the bus clock/reset domain and the chip logic, replacing the bus's procedural Read / parity_gen methods with a clocked, synthesizable port.

## Interface
Parameters:
- DATA_W, 64, width of data words for Read and parity.
- ADDR_W, 32, width of returned addresses.
- ADDR_BASE, 32'h0000_0000, first address issued after reset.
- ADDR_STRIDE, 8, address increment per accepted Read (bytes per 64-bit word).

Ports (one clock; reset is asynchronous and active-low; the clock and reset ports are named clock and resetN):
- clock  input  1  bus clock; all state updates on the rising edge.
- resetN  input  1  asynchronous, active-low reset.
- rd_req  input  1  Read request, sampled each rising edge.
- rd_data  input  DATA_W  data word carried with rd_req.
- rd_ack  output  1  one-cycle pulse; Read completed.
- rd_addr  output  ADDR_W  address assigned to the completed Read; valid while rd_ack=1.
- rd_data_q  output  DATA_W  captured rd_data of the completed Read.
- par_req  input  1  parity-call strobe, used only for call counting.
- par_data  input  DATA_W  word to be parity-checked.
- par_bit  output  1  combinational parity of par_data.
- rd_calls  output  16  accepted Read count (only with CHIP_BUS_CALL_COUNT_EN).
- par_calls  output  16  parity-call count (only with CHIP_BUS_CALL_COUNT_EN).

## Operation
- Address pointer addr_ptr (ADDR_W) resets to ADDR_BASE.
- On a rising edge with rd_req=1:
  - register rd_ack=1, rd_addr=addr_ptr, rd_data_q=rd_data;
  - addr_ptr += ADDR_STRIDE, modulo 2^ADDR_W (wraps silently past 32'hFFFF_FFFF).
- On a rising edge with rd_req=0: rd_ack=0; rd_addr and rd_data_q hold their last values.
- Back-to-back requests are legal: every cycle with rd_req=1 is accepted (no busy/stall).
- par_bit = XOR of all DATA_W bits of par_data. It is 1 when the count of ones is odd. Purely combinational, no latency.
- par_req has no effect on par_bit.
- Simultaneous rd_req and par_req are independent; both services operate and both counters increment in the same cycle.

## Timing
- Read latency: 1 cycle. A request sampled at edge N gives rd_ack high from edge N until edge N+1.
- Parity latency: 0 cycles (combinational path par_data → par_bit).
- Reset values:
  - rd_ack=0, rd_addr=0, rd_data_q=0;
  - addr_ptr=ADDR_BASE;
  - rd_calls=0, par_calls=0.
- Reset mid-operation: asserting resetN low clears rd_ack immediately (asynchronously); a request sampled on the edge before reset is dropped and does not complete. The first Read after release returns ADDR_BASE.
- Requests are ignored while resetN=0.

## Configuration
- Macro CHIP_BUS_CALL_COUNT_EN.
- Defined:
  - rd_calls increments on each accepted Read;
  - par_calls increments on each edge with par_req=1;
  - both saturate at 16'hFFFF.
- Undefined: the counters are not built, and rd_calls/par_calls are tied to 0. All other behaviour is identical.

## Structure
- Package chip_bus_pkg holds:
  - constants DATA_W, ADDR_W, ADDR_STRIDE;
  - typedefs data_t (logic [DATA_W-1:0]) and addr_t (logic [ADDR_W-1:0]);
  - count_t (logic [15:0]).
- One sub-module: chip_bus_parity, a DATA_W-wide XOR-reduction tree producing par_bit.
- Read sequencing and counters live in the top module.

## Test plan
- Reset, then one Read (rd_data=64'h0123_4567_89AB_CDEF) and one par_req (par_data=same) → rd_ack pulses once, rd_addr=32'h0, rd_data_q=64'h0123_4567_89AB_CDEF, par_bit=0 (32 ones). With CHIP_BUS_CALL_COUNT_EN: rd_calls=1, par_calls=1.
- Three back-to-back Reads → rd_ack high for 3 cycles, rd_addr=0, 8, 16; next pointer 24.
- Parity: par_data=64'h1 → par_bit=1; 64'hFFFF_FFFF_FFFF_FFFF → 0; 64'h0 → 0.
- Wrap: ADDR_BASE=32'hFFFF_FFF8, two Reads → rd_addr=32'hFFFF_FFF8 then 32'h0000_0000.
- Reset asserted the cycle after rd_req → rd_ack=0 immediately. After release, a Read returns ADDR_BASE and counters restart at 0.
- Counter saturation (macro defined): 65 540 par_req pulses → par_calls=16'hFFFF. Without the macro, both counters read 0 throughout.
